input_debouncer: RTL and testbench

- Conditions one raw, asynchronous switch or button input into a clean, glitch-free logic level for the gate stages (AND/OR/etc. inputs a/b).
- Sits directly upstream of each gate input: board pin -> input_debouncer -> gate.
- Provides a debounced level, one-cycle rise and fall pulses, and a toggle level, so a push-button can act as a latched gate operand.

---
 rtl/input_debouncer_if.sv | 29 ++
 rtl/input_debouncer.sv | 93 +++++++++
 tb/tb_input_debouncer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw switch/button source and its debouncer.
// Signalling: btn_in is a free-running asynchronous level with no handshake;
// level_out/toggle_out are registered levels and rise_pulse/fall_pulse are
// registered single-cycle strobes, all produced in the debouncer clock domain.
interface input_debouncer_if;
   logic btn_in;
   logic level_out;
   logic rise_pulse;
   logic fall_pulse;
   logic toggle_out;

   // Source side: drives the raw input, observes the conditioned outputs.
   modport master (
      output btn_in,
      input  level_out,
      input  rise_pulse,
      input  fall_pulse,
      input  toggle_out
   );

   // Debouncer side.
   modport slave (
      input  btn_in,
      output level_out,
      output rise_pulse,
      output fall_pulse,
      output toggle_out
   );
endinterface

// File: rtl/input_debouncer.sv
// Debouncer for one raw switch/button input.
// The raw input is brought into the clock domain through two flops; a change
// on the synchronized sample is committed to level_out only after it has
// differed from level_out for STABLE_CYCLES consecutive edges. Any sample
// that agrees with level_out clears the count, so bounce trains whose runs
// are shorter than STABLE_CYCLES never get through. Commits produce one-cycle
// rise/fall strobes, and every rising commit flips toggle_out so a button
// can act as a latched operand.
module input_debouncer #(
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input_debouncer_if.slave   bus
);

   // Terminal count: a differing sample seen while the counter holds this
   // value is the STABLE_CYCLES-th in a row and commits the new level.
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic                 r_s1;
   logic                 r_s2;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_level;
   logic                 r_rise;
   logic                 r_fall;
   logic                 r_toggle;

   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 w_level_nxt;
   logic                 w_rise_nxt;
   logic                 w_fall_nxt;
   logic                 w_toggle_nxt;

   // Two-flop synchronizer; only r_s2 is used by the stability logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= bus.btn_in;
         r_s2 <= r_s1;
      end
   end

   // Stability counter and commit decision; pulses default low every cycle.
   always_comb begin
      w_cnt_nxt    = '0;
      w_level_nxt  = r_level;
      w_rise_nxt   = 1'b0;
      w_fall_nxt   = 1'b0;
      w_toggle_nxt = r_toggle;
      if (r_s2 != r_level) begin
         if (r_cnt >= LAST_CNT) begin
            // Counter is cleared at commit, so it never wraps or saturates.
            w_cnt_nxt   = '0;
            w_level_nxt = r_s2;
            if (r_s2) begin
               w_rise_nxt   = 1'b1;
               w_toggle_nxt = ~r_toggle;
            end else begin
               w_fall_nxt   = 1'b1;
            end
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   // Debounce state registers; reset abandons any count in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_level  <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_toggle <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_level  <= w_level_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_toggle <= w_toggle_nxt;
      end
   end

   assign bus.level_out  = r_level;
   assign bus.rise_pulse = r_rise;
   assign bus.fall_pulse = r_fall;
   assign bus.toggle_out = r_toggle;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES=4, CNT_WIDTH=3.
// Outputs are compared as one 4-bit word {level, rise, fall, toggle},
// sampled 1 ns after each rising edge; inputs also change at that point.
module tb_input_debouncer;

   localparam int unsigned STABLE_CYCLES = 4;
   localparam int unsigned CNT_WIDTH     = 3;
   // Edge (counting the capture edge as the 1st) on which a clean step commits.
   localparam int COMMIT_TICK = STABLE_CYCLES + 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   input_debouncer_if bus ();

   input_debouncer #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] outs();
      return {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.toggle_out};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got {lvl,rise,fall,tgl}=%b, want %b at %0t", tag, obs, exp, $time);
   endtask

   // Walk a clean step: edges before the commit must show quiet_v, the commit
   // edge commit_v and the edge after it after_v.
   task automatic expect_step(input string tag, input logic [3:0] quiet_v,
                              input logic [3:0] commit_v, input logic [3:0] after_v);
      for (int i = 1; i < COMMIT_TICK; i++) begin
         tick();
         check($sformatf("%s_wait%0d", tag, i), outs(), quiet_v);
      end
      tick();
      check({tag, "_commit"}, outs(), commit_v);
      tick();
      check({tag, "_after"}, outs(), after_v);
   endtask

   initial begin
      logic [7:0] bounce_pat;
      logic [3:0] settle_pat;
      n_checks   = 0;
      n_pass     = 0;
      bounce_pat = 8'b1110_1110;
      settle_pat = 4'b1010;

      // Reset held 3 edges with the input high: everything stays 0.
      rst        = 1'b1;
      bus.btn_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset%0d", i), outs(), 4'b0000);
      end
      rst = 1'b0;
      // Input high through release is a fresh press: rise + toggle.
      expect_step("post_reset_rise", 4'b0000, 4'b1101, 4'b1001);

      // Release: fall pulse, toggle stays 1.
      bus.btn_in = 1'b0;
      expect_step("release1", 4'b1001, 4'b0011, 4'b0001);

      // Second press: rise pulse, toggle 1 -> 0.
      bus.btn_in = 1'b1;
      expect_step("press2", 4'b0001, 4'b1100, 4'b1000);

      // Release again so the level is 0 for the bounce test.
      bus.btn_in = 1'b0;
      expect_step("release2", 4'b1000, 4'b0010, 4'b0000);

      // Bounce with runs of 3 highs: nothing may commit in 40 cycles.
      for (int i = 0; i < 40; i++) begin
         bus.btn_in = bounce_pat[7 - (i % 8)];
         tick();
         check($sformatf("bounce%0d", i), outs(), 4'b0000);
      end
      bus.btn_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("bounce_quiet%0d", i), outs(), 4'b0000);
      end

      // Short bounce then a steady high: exactly one rise, toggle 0 -> 1.
      for (int i = 0; i < 4; i++) begin
         bus.btn_in = settle_pat[3 - i];
         tick();
         check($sformatf("settle_bounce%0d", i), outs(), 4'b0000);
      end
      bus.btn_in = 1'b1;
      expect_step("settle_rise", 4'b0000, 4'b1101, 4'b1001);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("settle_hold%0d", i), outs(), 4'b1001);
      end

      // Release: fall, toggle unchanged at 1.
      bus.btn_in = 1'b0;
      expect_step("release3", 4'b1001, 4'b0011, 4'b0001);

      // Reset on the 3rd counting edge abandons the count: no pulse.
      bus.btn_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("midcount%0d", i), outs(), 4'b0001);
      end
      rst = 1'b1;
      tick();
      check("midcount_reset", outs(), 4'b0000);
      rst = 1'b0;
      // Full latency again from the first post-reset edge.
      expect_step("post_midreset_rise", 4'b0000, 4'b1101, 4'b1001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL timeout: bench still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
